// File: rtl/frame_cfg_pkg.sv
// Shared types and header layout for the frame configuration sequencer.
// The header carries a marker nibble, a column field and a frame field.
package frame_cfg_pkg;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_DATA,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_e;

    localparam logic [3:0] HDR_MARKER     = 4'hF;
    localparam int         HDR_MARKER_LSB = 28;
    localparam int         HDR_COL_LSB    = 16;
    localparam int         HDR_FRAME_LSB  = 0;
    localparam int         HDR_FIELD_W    = 8;

    function automatic logic [3:0] hdr_marker(input logic [31:0] word);
        return word[HDR_MARKER_LSB +: 4];
    endfunction

    function automatic logic [HDR_FIELD_W-1:0] hdr_col(input logic [31:0] word);
        return word[HDR_COL_LSB +: HDR_FIELD_W];
    endfunction

    function automatic logic [HDR_FIELD_W-1:0] hdr_frame(input logic [31:0] word);
        return word[HDR_FRAME_LSB +: HDR_FIELD_W];
    endfunction

endpackage

// File: rtl/frame_strobe_decoder.sv
// One-hot decode of (column, frame) onto the flat FrameStrobe vector.
// Each output bit compares against constants, so no runtime multiply is built.
module frame_strobe_decoder
    import frame_cfg_pkg::*;
#(
    parameter int NumColumns      = 4,
    parameter int MaxFramesPerCol = 20
) (
    input  logic [HDR_FIELD_W-1:0]                 col,
    input  logic [HDR_FIELD_W-1:0]                 frame,
    input  logic                                   enable,
    output logic [NumColumns*MaxFramesPerCol-1:0]  strobe
);

    genvar gi, gj;
    generate
        for (gi = 0; gi < NumColumns; gi++) begin : g_col
            for (gj = 0; gj < MaxFramesPerCol; gj++) begin : g_frame
                assign strobe[gi*MaxFramesPerCol + gj] =
                    enable && (col == HDR_FIELD_W'(gi)) && (frame == HDR_FIELD_W'(gj));
            end
        end
    endgenerate

endmodule

// File: rtl/frame_config_sequencer.sv
// Receives header + NumRows data words and writes one configuration frame:
// FrameData is loaded a cycle before a one-hot FrameStrobe pulse and held after it.
module frame_config_sequencer
    import frame_cfg_pkg::*;
#(
    parameter int          NumRows         = 4,
    parameter int          NumColumns      = 4,
    parameter int          MaxFramesPerCol = 20,
    parameter int          FrameBitsPerRow = 32,
    parameter int          StrobeCycles    = 1,
    parameter logic [15:0] FrameCountInit  = 16'h0000
) (
    input  logic                                   UserCLK,
    input  logic                                   RST,
    input  logic [31:0]                            in_data,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic                                   abort,
    output logic [NumRows*FrameBitsPerRow-1:0]     FrameData,
    output logic [NumColumns*MaxFramesPerCol-1:0]  FrameStrobe,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   hdr_err,
    output logic [15:0]                            frame_count
);

    localparam int RowW = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam logic [RowW-1:0] LastRow = RowW'(NumRows - 1);
    localparam logic [3:0] LastStrobe = 4'(StrobeCycles - 1);
    localparam int StrobeW = NumColumns * MaxFramesPerCol;

    state_e                      state_q, state_d;
    logic [HDR_FIELD_W-1:0]      col_q, col_d, frame_q, frame_d;
    logic [RowW-1:0]             row_cnt_q, row_cnt_d;
    logic [3:0]                  strobe_cnt_q, strobe_cnt_d;
    logic [FrameBitsPerRow-1:0]  shadow_q [NumRows];
    logic [FrameBitsPerRow-1:0]  shadow_d [NumRows];
    logic [FrameBitsPerRow-1:0]  frame_data_q [NumRows];
    logic [FrameBitsPerRow-1:0]  frame_data_d [NumRows];
    logic [StrobeW-1:0]          frame_strobe_q, frame_strobe_d;
    logic [15:0]                 frame_count_q, frame_count_d;
    logic                        hdr_err_q, hdr_err_d;
    logic                        ready_c;
    logic                        hdr_ok;

    // Column is widened by one bit so a limit of 256 still compares correctly.
    assign hdr_ok = (hdr_marker(in_data) == HDR_MARKER)
                 && ({1'b0, hdr_col(in_data)} < 9'(NumColumns))
                 && ({1'b0, hdr_frame(in_data)} < 9'(MaxFramesPerCol));

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        frame_d       = frame_q;
        row_cnt_d     = row_cnt_q;
        strobe_cnt_d  = strobe_cnt_q;
        shadow_d      = shadow_q;
        frame_data_d  = frame_data_q;
        frame_count_d = frame_count_q;
        hdr_err_d     = hdr_err_q;
        ready_c       = 1'b0;
        case (state_q)
            ST_HDR: begin
                ready_c = 1'b1;
                if (in_valid) begin
                    if (hdr_ok) begin
                        col_d     = hdr_col(in_data);
                        frame_d   = hdr_frame(in_data);
                        row_cnt_d = '0;
                        state_d   = ST_DATA;
                    end else begin
                        hdr_err_d = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                // Abort takes priority and blocks the handshake in the same cycle.
                if (abort) begin
                    row_cnt_d = '0;
                    state_d   = ST_HDR;
                end else begin
                    ready_c = 1'b1;
                    if (in_valid) begin
                        shadow_d[row_cnt_q] = in_data;
                        row_cnt_d = row_cnt_q + 1'b1;
                        if (row_cnt_q == LastRow) begin
                            row_cnt_d = '0;
                            state_d   = ST_SETUP;
                        end
                    end
                end
            end
            ST_SETUP: begin
                strobe_cnt_d = '0;
                state_d      = ST_STROBE;
            end
            ST_STROBE: begin
                if (strobe_cnt_q == LastStrobe) begin
                    state_d = ST_HOLD;
                end else begin
                    strobe_cnt_d = strobe_cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                frame_count_d = frame_count_q + 16'd1;
                state_d       = ST_HDR;
            end
            default: state_d = ST_HDR;
        endcase
        // Load on entry to SETUP so data is settled a full cycle before the strobe.
        if (state_q == ST_DATA && state_d == ST_SETUP) begin
            frame_data_d = shadow_d;
        end
    end

    frame_strobe_decoder #(
        .NumColumns      (NumColumns),
        .MaxFramesPerCol (MaxFramesPerCol)
    ) u_decoder (
        .col    (col_q),
        .frame  (frame_q),
        .enable (state_d == ST_STROBE),
        .strobe (frame_strobe_d)
    );

    always_ff @(posedge UserCLK or posedge RST) begin
        if (RST) begin
            state_q        <= ST_HDR;
            col_q          <= '0;
            frame_q        <= '0;
            row_cnt_q      <= '0;
            strobe_cnt_q   <= '0;
            frame_strobe_q <= '0;
            frame_count_q  <= FrameCountInit;
            hdr_err_q      <= 1'b0;
            for (int r = 0; r < NumRows; r++) begin
                shadow_q[r]     <= '0;
                frame_data_q[r] <= '0;
            end
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            frame_q        <= frame_d;
            row_cnt_q      <= row_cnt_d;
            strobe_cnt_q   <= strobe_cnt_d;
            frame_strobe_q <= frame_strobe_d;
            frame_count_q  <= frame_count_d;
            hdr_err_q      <= hdr_err_d;
            shadow_q       <= shadow_d;
            frame_data_q   <= frame_data_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NumRows; gi++) begin : g_row
            assign FrameData[gi*FrameBitsPerRow +: FrameBitsPerRow] = frame_data_q[gi];
        end
    endgenerate

    assign FrameStrobe = frame_strobe_q;
    assign in_ready    = ready_c && !RST;
    assign busy        = (state_q != ST_HDR);
    assign done        = (state_q == ST_HOLD);
    assign hdr_err     = hdr_err_q;
    assign frame_count = frame_count_q;

    assert property (@(posedge UserCLK) disable iff (RST) $onehot0(frame_strobe_q));
    assert property (@(posedge UserCLK) disable iff (RST)
                     (frame_strobe_q != '0) |-> (state_q == ST_STROBE));

endmodule
